// File: rtl/instr_queue.sv
// Instruction queue: decoupling FIFO between the fetch unit and decode.
// Strict program order, no bypass, synchronous flush clears all entries.
module instr_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ILEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [ILEN-1:0]            instruction_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [ILEN-1:0]            instruction_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [ILEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;
    logic            push;
    logic            pop;

    // Ready depends on state only, so a full queue refuses a push even while popping.
    assign fetch_ready_o = (cnt_q != CW'(DEPTH));
    assign issue_valid_o = (cnt_q != '0);
    assign instruction_o = mem_q[rd_q];
    assign count_o       = cnt_q;

    assign push = fetch_valid_i & fetch_ready_o;
    assign pop  = issue_valid_o & issue_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= instruction_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_cnt_bound : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        cnt_q <= CW'(DEPTH));
    a_ptr_rel : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        wr_q == AW'(rd_q + cnt_q[AW-1:0]));
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push && cnt_q == CW'(DEPTH)));
    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(pop && cnt_q == '0));

endmodule

// File: tb/tb_instr_queue.sv
// Directed and scoreboard checks for instr_queue.
// Inputs change 1 time unit after posedge; outputs are checked before the next edge.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int ILEN  = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            fetch_valid;
    logic            fetch_ready;
    logic [ILEN-1:0] instr_in;
    logic            issue_valid;
    logic            issue_ready;
    logic [ILEN-1:0] instr_out;
    logic [2:0]      count;

    int n_chk;
    int n_fail;

    instr_queue #(.DEPTH(DEPTH), .ILEN(ILEN)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .fetch_valid_i (fetch_valid),
        .fetch_ready_o (fetch_ready),
        .instruction_i (instr_in),
        .issue_valid_o (issue_valid),
        .issue_ready_i (issue_ready),
        .instruction_o (instr_out),
        .count_o       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        instr_in    = '0;
    endtask

    logic [ILEN-1:0] model[$];
    logic [ILEN-1:0] a_data[4];
    int              sz;
    logic            fv;
    logic            ir;
    logic            fl;
    logic [ILEN-1:0] d;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        a_data[0] = 32'hA000_0001;
        a_data[1] = 32'hB000_0002;
        a_data[2] = 32'hC000_0003;
        a_data[3] = 32'hD000_0004;
        idle_in();
        rst_n = 1'b0;
        #22;
        rst_n = 1'b1;
        step();

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", issue_valid, 0);
            chk("idle_ready", fetch_ready, 1);
            chk("idle_count", count, 0);
            step();
        end
        chk("rst_instr", instr_out, 0);

        // Single pass
        fetch_valid = 1'b1;
        issue_ready = 1'b1;
        instr_in    = 32'h0000_0013;
        step();
        fetch_valid = 1'b0;
        chk("single_valid", issue_valid, 1);
        chk("single_data", instr_out, 32'h13);
        chk("single_cnt1", count, 1);
        step();
        chk("single_cnt0", count, 0);
        chk("single_empty", issue_valid, 0);

        // Fill to full, 5th push refused, drain in order
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_valid = 1'b1;
            instr_in    = a_data[i];
            step();
        end
        chk("fill_cnt", count, 4);
        chk("fill_ready", fetch_ready, 0);
        instr_in = 32'hEEEE_EEEE;
        step();
        chk("fill_5th_cnt", count, 4);
        fetch_valid = 1'b0;
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", issue_valid, 1);
            chk("drain_data", instr_out, a_data[i]);
            step();
        end
        chk("drain_cnt", count, 0);
        chk("drain_ready", fetch_ready, 1);

        // Steady streaming
        fetch_valid = 1'b1;
        issue_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr_in = 32'h100 + i;
            step();
            chk("stream_cnt", count, 1);
            chk("stream_data", instr_out, 32'h100 + i);
        end
        fetch_valid = 1'b0;
        step();
        chk("stream_end_cnt", count, 0);

        // Flush together with push and pop
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            instr_in    = 32'h200 + i;
            step();
        end
        chk("pre_flush_cnt", count, 3);
        flush       = 1'b1;
        issue_ready = 1'b1;
        instr_in    = 32'h2FF;
        step();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        chk("flush_cnt", count, 0);
        chk("flush_valid", issue_valid, 0);
        chk("flush_ready", fetch_ready, 1);
        fetch_valid = 1'b1;
        instr_in    = 32'h0BAD_F00D;
        step();
        fetch_valid = 1'b0;
        chk("post_flush_data", instr_out, 32'h0BAD_F00D);
        chk("post_flush_cnt", count, 1);

        // Async reset mid-operation
        fetch_valid = 1'b1;
        instr_in    = 32'h333;
        step();
        fetch_valid = 1'b0;
        chk("pre_rst_cnt", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", count, 0);
        chk("arst_valid", issue_valid, 0);
        chk("arst_ready", fetch_ready, 1);
        chk("arst_instr", instr_out, 0);
        step();
        rst_n = 1'b1;
        step();

        // Random scoreboard
        model.delete();
        for (int c = 0; c < 10000; c++) begin
            fv = 1'($urandom_range(0, 1));
            ir = 1'($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 99) == 0);
            d  = $urandom;
            flush       = fl;
            fetch_valid = fv;
            issue_ready = ir;
            instr_in    = d;
            #1;
            sz = model.size();
            chk("rnd_cnt", count, sz);
            chk("rnd_ready", fetch_ready, sz != DEPTH);
            chk("rnd_valid", issue_valid, sz != 0);
            if (sz != 0) chk("rnd_data", instr_out, model[0]);
            if (fl) begin
                model.delete();
            end else begin
                if (ir && sz != 0) void'(model.pop_front());
                if (fv && sz != DEPTH) model.push_back(d);
            end
            step();
        end
        idle_in();
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
